// File: rtl/pipelined_control_unit.sv
// ID stage of the RISCY core: decodes IF/ID into the ID/EX control register,
// detects load-use hazards, and keeps saturating stall/flush counters.
module pipelined_control_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [31:0]           instruction,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_branch_ne,
  output logic                  ex_jump,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_dest_reg,
  output logic                  ex_illegal,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_XORI  = 6'b010010;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_BNE   = 6'b010100;
  localparam logic [5:0] OP_LW    = 6'b010101;
  localparam logic [5:0] OP_SW    = 6'b010110;
  localparam logic [5:0] OP_SLT   = 6'b010111;
  localparam logic [5:0] OP_SLTI  = 6'b011000;
  localparam logic [5:0] OP_JUMP  = 6'b110000;

  typedef struct packed {
    logic                  valid;
    logic                  reg_dst;
    logic                  alu_src;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  branch_ne;
    logic                  jump;
    logic [ALUOP_W-1:0]    alu_op;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  illegal;
  } idex_t;

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic                  unused_instr_bits;
  idex_t                 dec, ex_d, ex_q;
  logic                  rs_used, rt_used, hz_c;
  logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  assign opcode            = instruction[31:26];
  assign rs                = REG_ADDR_W'(instruction[25:21]);
  assign rt                = REG_ADDR_W'(instruction[20:16]);
  assign rd                = REG_ADDR_W'(instruction[15:11]);
  assign unused_instr_bits = ^instruction[10:0];

  // Instruction decode plus which register fields are read as sources
  always_comb begin
    dec     = '0;
    rs_used = 1'b1;
    rt_used = 1'b0;
    case (opcode)
      OP_RTYPE, OP_SLT: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_op = ALUOP_W'(3'b010); rt_used = 1'b1;
      end
      OP_ADDI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(3'b011); end
      OP_ANDI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(3'b100); end
      OP_XORI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(3'b101); end
      OP_SLTI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOP_W'(3'b110); end
      OP_BEQ: begin dec.branch = 1'b1; dec.alu_op = ALUOP_W'(3'b001); rt_used = 1'b1; end
      OP_BNE: begin
        dec.branch = 1'b1; dec.branch_ne = 1'b1;
        dec.alu_op = ALUOP_W'(3'b001); rt_used = 1'b1;
      end
      OP_LW: begin
        dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1;
        dec.reg_write = 1'b1; dec.mem_read = 1'b1;
      end
      OP_SW: begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; rt_used = 1'b1; end
      OP_JUMP: begin dec.jump = 1'b1; rs_used = 1'b0; end
      default: dec.illegal = 1'b1;
    endcase
    dec.valid    = 1'b1;
    dec.dest_reg = dec.reg_dst ? rd : rt;
  end

  // Load in EX whose destination feeds a source of the ID instruction
  assign hz_c = ex_q.valid & ex_q.mem_read & (ex_q.dest_reg != '0) & id_valid &
                ((rs_used & (ex_q.dest_reg == rs)) | (rt_used & (ex_q.dest_reg == rt)));

  assign stall = hz_c & ~flush & ~reset;

  // Priority: flush, hold, hazard bubble, normal load
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      ex_d = '0;
      if (id_valid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (hold) begin
      ex_d = ex_q;
    end else if (hz_c) begin
      ex_d = '0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      ex_d = id_valid ? dec : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_branch     = ex_q.branch;
  assign ex_branch_ne  = ex_q.branch_ne;
  assign ex_jump       = ex_q.jump;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_dest_reg   = ex_q.dest_reg;
  assign ex_illegal    = ex_q.illegal;
  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: decode vector table, hand-built hazard,
// flush and hold sequences, then random traffic against a reference model.
module tb_pipelined_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, id_valid, flush, hold;
  logic [31:0] instruction;
  logic        stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic        ex_mem_read, ex_mem_write, ex_branch, ex_branch_ne, ex_jump, ex_illegal;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_dest_reg;
  logic [15:0] stall_count, flush_count;

  logic        s_stall, s_valid, s_reg_dst, s_alu_src, s_mem_to_reg, s_reg_write;
  logic        s_mem_read, s_mem_write, s_branch, s_branch_ne, s_jump, s_illegal;
  logic [2:0]  s_alu_op;
  logic [4:0]  s_dest_reg;
  logic [1:0]  s_stall_count, s_flush_count;

  pipelined_control_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .instruction(instruction),
    .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_jump(ex_jump),
    .ex_alu_op(ex_alu_op), .ex_dest_reg(ex_dest_reg), .ex_illegal(ex_illegal),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipelined_control_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .instruction(instruction),
    .flush(flush), .hold(hold), .stall(s_stall), .ex_valid(s_valid),
    .ex_reg_dst(s_reg_dst), .ex_alu_src(s_alu_src), .ex_mem_to_reg(s_mem_to_reg),
    .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
    .ex_branch(s_branch), .ex_branch_ne(s_branch_ne), .ex_jump(s_jump),
    .ex_alu_op(s_alu_op), .ex_dest_reg(s_dest_reg), .ex_illegal(s_illegal),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  logic [18:0] act_ex;
  assign act_ex = {ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                   ex_mem_write, ex_branch, ex_branch_ne, ex_jump, ex_alu_op, ex_dest_reg, ex_illegal};

  // ctl order: RegDst ALUSrc MemToReg RegWrite MemRead MemWrite Branch BranchNe Jump
  typedef struct packed {
    bit       v;
    bit [8:0] ctl;
    bit [2:0] alu;
    bit [4:0] dest;
    bit       ill;
  } exp_t;

  typedef struct { bit [5:0] op; bit [8:0] ctl; bit [2:0] alu; } op_t;
  typedef struct { bit [31:0] ins; bit [8:0] ctl; bit [2:0] alu; bit [4:0] dest; bit ill; } vec_t;

  localparam bit [5:0] LW = 6'b010101, SW = 6'b010110, RT = 6'b000000, ADDI = 6'b010000;
  localparam bit [5:0] BEQ = 6'b010011;

  op_t  ops[11];
  vec_t vecs[12];
  exp_t m;
  int   m_sc, m_fc;
  int   checks = 0, errors = 0;
  bit   obs_stall;

  function automatic bit [31:0] mk(input bit [5:0] op, input bit [4:0] rs, rt, rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic exp_t ref_dec(input bit [31:0] ins);
    exp_t e;
    e = '0;
    e.v = 1'b1;
    e.ill = 1'b1;
    foreach (ops[i]) begin
      if (ops[i].op == ins[31:26]) begin
        e.ctl = ops[i].ctl;
        e.alu = ops[i].alu;
        e.ill = 1'b0;
      end
    end
    e.dest = e.ctl[8] ? ins[15:11] : ins[20:16];
    return e;
  endfunction

  function automatic bit ref_hz(input bit v, input bit [31:0] ins);
    bit [5:0] op;
    bit use_rs, use_rt;
    op = ins[31:26];
    use_rs = (op != 6'b110000);
    use_rt = (op inside {6'b000000, 6'b010111, 6'b010011, 6'b010100, 6'b010110});
    return m.v && m.ctl[4] && (m.dest != 5'd0) && v &&
           ((use_rs && m.dest == ins[25:21]) || (use_rt && m.dest == ins[20:16]));
  endfunction

  function automatic int satv(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, check comb stall before the edge, advance model, check registers after
  task automatic cycle(input bit r, input bit v, input bit [31:0] ins, input bit f, input bit h);
    bit hz;
    reset = r; id_valid = v; instruction = ins; flush = f; hold = h;
    #1;
    hz = ref_hz(v, ins);
    obs_stall = stall;
    chk("stall", 32'(stall), 32'(hz && !f && !r));
    @(posedge clk);
    if (r) begin m = '0; m_sc = 0; m_fc = 0; end
    else if (f) begin m = '0; if (v) m_fc++; end
    else if (h) begin m = m; end
    else if (hz) begin m = '0; m_sc++; end
    else m = v ? ref_dec(ins) : '0;
    #1;
    chk("ex_bundle", 32'(act_ex), 32'(m));
    chk("stall_count", 32'(stall_count), 32'(satv(m_sc, 16)));
    chk("flush_count", 32'(flush_count), 32'(satv(m_fc, 16)));
    chk("sat_stall_count", 32'(s_stall_count), 32'(satv(m_sc, 2)));
    chk("sat_flush_count", 32'(s_flush_count), 32'(satv(m_fc, 2)));
  endtask

  initial begin
    ops[0]  = '{6'b000000, 9'b100100000, 3'b010};
    ops[1]  = '{6'b010000, 9'b010100000, 3'b011};
    ops[2]  = '{6'b010001, 9'b010100000, 3'b100};
    ops[3]  = '{6'b010010, 9'b010100000, 3'b101};
    ops[4]  = '{6'b010011, 9'b000000100, 3'b001};
    ops[5]  = '{6'b010100, 9'b000000110, 3'b001};
    ops[6]  = '{6'b010101, 9'b011110000, 3'b000};
    ops[7]  = '{6'b010110, 9'b010001000, 3'b000};
    ops[8]  = '{6'b010111, 9'b100100000, 3'b010};
    ops[9]  = '{6'b011000, 9'b010100000, 3'b110};
    ops[10] = '{6'b110000, 9'b000000001, 3'b000};

    vecs[0]  = '{mk(6'b000000, 1, 2, 3), 9'b100100000, 3'b010, 5'd3, 1'b0};
    vecs[1]  = '{mk(6'b010000, 1, 2, 3), 9'b010100000, 3'b011, 5'd2, 1'b0};
    vecs[2]  = '{mk(6'b010001, 1, 2, 3), 9'b010100000, 3'b100, 5'd2, 1'b0};
    vecs[3]  = '{mk(6'b010010, 1, 2, 3), 9'b010100000, 3'b101, 5'd2, 1'b0};
    vecs[4]  = '{mk(6'b010011, 1, 2, 3), 9'b000000100, 3'b001, 5'd2, 1'b0};
    vecs[5]  = '{mk(6'b010100, 1, 2, 3), 9'b000000110, 3'b001, 5'd2, 1'b0};
    vecs[6]  = '{mk(6'b010101, 1, 0, 3), 9'b011110000, 3'b000, 5'd0, 1'b0};
    vecs[7]  = '{mk(6'b010110, 1, 2, 3), 9'b010001000, 3'b000, 5'd2, 1'b0};
    vecs[8]  = '{mk(6'b010111, 1, 2, 3), 9'b100100000, 3'b010, 5'd3, 1'b0};
    vecs[9]  = '{mk(6'b011000, 1, 2, 3), 9'b010100000, 3'b110, 5'd2, 1'b0};
    vecs[10] = '{mk(6'b110000, 1, 2, 3), 9'b000000001, 3'b000, 5'd2, 1'b0};
    vecs[11] = '{mk(6'b111111, 1, 2, 3), 9'b000000000, 3'b000, 5'd2, 1'b1};

    m = '0; m_sc = 0; m_fc = 0;

    // Reset with addi presented
    cycle(1, 1, mk(ADDI, 1, 2, 3), 0, 0);
    cycle(1, 1, mk(ADDI, 1, 2, 3), 0, 0);
    chk("reset_ex", 32'(act_ex), 32'd0);
    chk("reset_counts", 32'({stall_count, flush_count}), 32'd0);

    // Decode sweep
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, vecs[i].ins, 0, 0);
      chk("sweep", 32'(act_ex),
          32'({1'b1, vecs[i].ctl, vecs[i].alu, vecs[i].dest, vecs[i].ill}));
    end

    // Load-use: one stall cycle then the consumer decodes
    cycle(1, 0, 32'd0, 0, 0);
    cycle(0, 1, mk(LW, 1, 5, 0), 0, 0);
    cycle(0, 1, mk(RT, 5, 6, 7), 0, 0);
    chk("lu_stall", 32'(obs_stall), 32'd1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    cycle(0, 1, mk(RT, 5, 6, 7), 0, 0);
    chk("lu_release", 32'(obs_stall), 32'd0);
    chk("lu_add", 32'({ex_valid, ex_reg_dst, ex_dest_reg}), 32'({1'b1, 1'b1, 5'd7}));
    chk("lu_count", 32'(stall_count), 32'd1);
    cycle(0, 1, mk(LW, 1, 0, 0), 0, 0);
    cycle(0, 1, mk(RT, 0, 6, 7), 0, 0);
    chk("lu_r0", 32'(obs_stall), 32'd0);
    cycle(0, 1, mk(LW, 1, 5, 0), 0, 0);
    cycle(0, 1, mk(ADDI, 3, 5, 0), 0, 0);
    chk("lu_addi_rt", 32'(obs_stall), 32'd0);

    // Flush cases
    cycle(0, 1, mk(BEQ, 1, 2, 0), 1, 0);
    chk("flush_bubble", 32'(ex_valid), 32'd0);
    chk("flush_cnt", 32'(flush_count), 32'd1);
    cycle(0, 0, mk(BEQ, 1, 2, 0), 1, 0);
    chk("flush_idle", 32'(flush_count), 32'd1);
    cycle(0, 1, mk(LW, 1, 5, 0), 0, 0);
    cycle(0, 1, mk(RT, 5, 6, 7), 1, 0);
    chk("flush_hz_stall", 32'(obs_stall), 32'd0);

    // Hold keeps sw while lw waits
    cycle(0, 1, mk(SW, 1, 2, 0), 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, mk(LW, 1, 4, 0), 0, 1);
      chk("hold_keep", 32'({ex_mem_write, ex_mem_read}), 32'b10);
    end
    cycle(0, 1, mk(LW, 1, 4, 0), 0, 0);
    chk("hold_release", 32'({ex_mem_write, ex_mem_read}), 32'b01);

    // Hold beats hazard, then reset mid-hold/stall
    cycle(0, 1, mk(RT, 4, 6, 7), 0, 1);
    chk("hold_hz_stall", 32'(obs_stall), 32'd1);
    cycle(1, 1, mk(RT, 4, 6, 7), 0, 1);
    chk("rst_mid_stall", 32'(obs_stall), 32'd0);
    chk("rst_mid_ex", 32'({act_ex, stall_count}), 32'd0);

    // Saturation: five load-use stalls
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, mk(LW, 1, 5, 0), 0, 0);
      cycle(0, 1, mk(RT, 5, 6, 7), 0, 0);
    end
    chk("sat_main", 32'(stall_count), 32'd5);
    chk("sat_small", 32'(s_stall_count), 32'd3);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit [5:0] op;
      if ($urandom_range(0, 3) == 0) op = LW;
      else if ($urandom_range(0, 7) == 0) op = 6'($urandom());
      else op = ops[$urandom_range(0, 10)].op;
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85,
            mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
